// File: rtl/mips_pkg.sv
// Shared MIPS CPU definitions: datapath width, memory-op encodings and the
// memory-stage state enumeration, plus small op classification helpers.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LBU  = 4'd2;
    localparam logic [3:0] MEM_LH   = 4'd3;
    localparam logic [3:0] MEM_LHU  = 4'd4;
    localparam logic [3:0] MEM_LW   = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RMW_READ,
        ST_RMW_WRITE
    } mem_state_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr);
        logic half_op;
        logic word_op;
        half_op = (op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH);
        word_op = (op == MEM_LW) || (op == MEM_SW);
        return (half_op && addr[0]) || (word_op && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extracts and extends a load value from a bus
// word, and merges sub-word store data into the previously read bus word.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] bus_word,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_value,
    output logic [XLEN-1:0] store_word
);

    logic [7:0]  bus_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            localparam logic       HIGH = (gi >= 2);
            logic byte_hit;
            logic half_hit;

            assign bus_byte[gi] = bus_word[8*gi +: 8];
            assign byte_hit     = (op == MEM_SB) && (addr == LANE);
            assign half_hit     = (op == MEM_SH) && (addr[1] == HIGH);

            // A halfword store places its low byte in the even lane and its
            // high byte in the odd lane of the selected half.
            always_comb begin
                store_word[8*gi +: 8] = bus_byte[gi];
                if (op == MEM_SW) begin
                    store_word[8*gi +: 8] = store_data[8*gi +: 8];
                end else if (byte_hit) begin
                    store_word[8*gi +: 8] = store_data[7:0];
                end else if (half_hit) begin
                    store_word[8*gi +: 8] = store_data[8*(gi%2) +: 8];
                end
            end
        end
    endgenerate

    assign sel_byte = bus_byte[addr];
    assign sel_half = addr[1] ? bus_word[31:16] : bus_word[15:0];

    always_comb begin
        load_value = bus_word;
        case (op)
            MEM_LB:  load_value = {{24{sel_byte[7]}}, sel_byte};
            MEM_LBU: load_value = {24'd0, sel_byte};
            MEM_LH:  load_value = {{16{sel_half[15]}}, sel_half};
            MEM_LHU: load_value = {16'd0, sel_half};
            default: load_value = bus_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: captures execute results, runs word/sub-word bus
// cycles (sub-word stores via read-modify-write) and registers write-back.
module mem_stage
    import mips_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [4:0]      ex_dst,
    input  logic            ex_write_back,
    input  logic [3:0]      ex_mem_op,
    input  logic            DReady,
    output logic [XLEN-1:0] DAddr,
    inout  wire  [XLEN-1:0] Data,
    output logic            DRead,
    output logic            DWrite,
    output logic            mem_stall,
    output logic [4:0]      wb_dst,
    output logic [XLEN-1:0] wb_result,
    output logic            wb_write_back,
    output logic            misalign_exc
);

    mem_state_t      state_reg, state_next;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] write_word_reg;
    logic [3:0]      op_reg;
    logic [4:0]      dst_reg;
    logic            wbe_reg;
    logic [4:0]      wb_dst_reg;
    logic [XLEN-1:0] wb_result_reg;
    logic            wb_write_back_reg;
    logic            misalign_reg;

    logic [XLEN-1:0] load_value;
    logic [XLEN-1:0] merged_word;
    logic            ex_misaligned;

    assign ex_misaligned = is_misaligned(ex_mem_op, ex_result[1:0]);

    mem_lane_align u_align (
        .op         (op_reg),
        .addr       (addr_reg[1:0]),
        .bus_word   (Data),
        .store_data (write_word_reg),
        .load_value (load_value),
        .store_word (merged_word)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!ex_misaligned) begin
                    if (is_load(ex_mem_op)) begin
                        state_next = ST_READ;
                    end else if (ex_mem_op == MEM_SW) begin
                        state_next = ST_WRITE;
                    end else if (is_store(ex_mem_op)) begin
                        state_next = ST_RMW_READ;
                    end
                end
            end
            ST_READ:      if (DReady) state_next = ST_IDLE;
            ST_WRITE:     if (DReady) state_next = ST_IDLE;
            ST_RMW_READ:  if (DReady) state_next = ST_RMW_WRITE;
            ST_RMW_WRITE: if (DReady) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_reg          <= '0;
            write_word_reg    <= '0;
            op_reg            <= MEM_NONE;
            dst_reg           <= '0;
            wbe_reg           <= 1'b0;
            wb_dst_reg        <= '0;
            wb_result_reg     <= '0;
            wb_write_back_reg <= 1'b0;
            misalign_reg      <= 1'b0;
        end else begin
            wb_write_back_reg <= 1'b0;
            misalign_reg      <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    addr_reg       <= ex_result;
                    write_word_reg <= ex_store_data;
                    op_reg         <= ex_mem_op;
                    dst_reg        <= ex_dst;
                    wbe_reg        <= ex_write_back;
                    if (ex_misaligned) begin
                        misalign_reg <= 1'b1;
                    end else if (!is_load(ex_mem_op) && !is_store(ex_mem_op)) begin
                        // Unused op codes pass the ALU result through like MEM_NONE.
                        wb_result_reg     <= ex_result;
                        wb_dst_reg        <= ex_dst;
                        wb_write_back_reg <= ex_write_back;
                    end
                end
                ST_READ: begin
                    if (DReady) begin
                        wb_result_reg     <= load_value;
                        wb_dst_reg        <= dst_reg;
                        wb_write_back_reg <= wbe_reg;
                    end
                end
                ST_RMW_READ: begin
                    if (DReady) begin
                        write_word_reg <= merged_word;
                    end
                end
                default: ;
            endcase
        end
    end

    assign DRead     = (state_reg == ST_READ)  || (state_reg == ST_RMW_READ);
    assign DWrite    = (state_reg == ST_WRITE) || (state_reg == ST_RMW_WRITE);
    assign DAddr     = (DRead || DWrite) ? {2'b00, addr_reg[XLEN-1:2]} : '0;
    assign Data      = DWrite ? write_word_reg : 'z;
    assign mem_stall = (state_reg != ST_IDLE);

    assign wb_dst        = wb_dst_reg;
    assign wb_result     = wb_result_reg;
    assign wb_write_back = wb_write_back_reg;
    assign misalign_exc  = misalign_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, randomized ops
// against a behavioural memory model, and reset-in-flight sequences.
module tb_mem_stage;
    import mips_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] ex_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dst;
    logic        ex_write_back;
    logic [3:0]  ex_mem_op;
    logic        dready;
    logic [31:0] daddr;
    wire  [31:0] bus_data;
    logic        dread;
    logic        dwrite;
    logic        mem_stall;
    logic [4:0]  wb_dst;
    logic [31:0] wb_result;
    logic        wb_write_back;
    logic        misalign_exc;

    logic [31:0] mem [256];

    int checks   = 0;
    int failures = 0;

    mem_stage dut (
        .Clk           (clk),
        .Reset         (rst),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_dst        (ex_dst),
        .ex_write_back (ex_write_back),
        .ex_mem_op     (ex_mem_op),
        .DReady        (dready),
        .DAddr         (daddr),
        .Data          (bus_data),
        .DRead         (dread),
        .DWrite        (dwrite),
        .mem_stall     (mem_stall),
        .wb_dst        (wb_dst),
        .wb_result     (wb_result),
        .wb_write_back (wb_write_back),
        .misalign_exc  (misalign_exc)
    );

    assign bus_data = dread ? mem[daddr[7:0]] : 32'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  dst;
        logic        wb;
        int          delay;
        logic [31:0] init_word;
        logic [31:0] exp_result;
        logic [31:0] exp_word;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: lanes computed with shifts and masks on whole words.
    function automatic logic ref_misaligned(input logic [3:0] op, input logic [31:0] a);
        if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return (a % 2) != 0;
        if (op == MEM_LW || op == MEM_SW) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (op)
            MEM_LB:  return (b >= 32'd128) ? b - 32'd256 : b;
            MEM_LBU: return b;
            MEM_LH:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            MEM_LHU: return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] old, input logic [31:0] sd);
        logic [31:0] mask;
        int sh;
        case (op)
            MEM_SW: return sd;
            MEM_SB: begin
                sh = 8 * (a % 4);
                mask = 32'hFF << sh;
                return (old & ~mask) | ((sd & 32'hFF) << sh);
            end
            MEM_SH: begin
                sh = 16 * ((a / 2) % 2);
                mask = 32'hFFFF << sh;
                return (old & ~mask) | ((sd & 32'hFFFF) << sh);
            end
            default: return old;
        endcase
    endfunction

    task automatic run_op(input vec_t v, input int idx);
        int stall, rc, wc, held, exp_bus;
        logic bad_addr, bad_data, both;
        logic load_op, store_op, mis;
        logic [7:0] widx;
        logic [31:0] follow;
        widx     = v.addr[9:2];
        mem[widx] = v.init_word;
        mis      = ref_misaligned(v.op, v.addr);
        load_op  = !mis && (v.op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW});
        store_op = !mis && (v.op inside {MEM_SB, MEM_SH, MEM_SW});
        follow   = 32'hC0DE0000 | 32'(idx);

        @(negedge clk);
        ex_mem_op = v.op; ex_result = v.addr; ex_store_data = v.sdata;
        ex_dst = v.dst; ex_write_back = v.wb; dready = 1'b0;
        @(posedge clk);
        #1;
        ex_mem_op = MEM_NONE; ex_write_back = 1'b0; ex_result = follow; ex_dst = 5'd0;

        stall = 0; rc = 0; wc = 0; held = 0;
        bad_addr = 0; bad_data = 0; both = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!mem_stall) break;
            stall++;
            if (dread) rc++;
            if (dwrite) wc++;
            if (dread && dwrite) both = 1;
            if ((dread || dwrite) && daddr !== (v.addr >> 2)) bad_addr = 1;
            if (dwrite && bus_data !== v.exp_word) bad_data = 1;
            if (held >= v.delay) begin
                dready = 1'b1;
                held = 0;
                if (dwrite) mem[daddr[7:0]] = bus_data;
            end else begin
                dready = 1'b0;
                held++;
            end
        end
        dready = 1'b0;

        exp_bus = v.delay + 1;
        $display("op=%0d addr=%h sdata=%h delay=%0d wb_result=%h wb_we=%0d exc=%0d stall=%0d mem=%h",
                 v.op, v.addr, v.sdata, v.delay, wb_result, wb_write_back, misalign_exc,
                 stall, mem[widx]);

        if (load_op) begin
            check("stall_cycles", 32'(stall), 32'(exp_bus));
            check("read_cycles", 32'(rc), 32'(exp_bus));
            check("write_cycles", 32'(wc), 32'd0);
        end else if (store_op) begin
            check("stall_cycles", 32'(stall), 32'((v.op == MEM_SW) ? exp_bus : 2 * exp_bus));
            check("read_cycles", 32'(rc), 32'((v.op == MEM_SW) ? 0 : exp_bus));
            check("write_cycles", 32'(wc), 32'(exp_bus));
        end else begin
            check("stall_cycles", 32'(stall), 32'd0);
        end
        check("strobes_exclusive", 32'(both), 32'd0);
        check("daddr", 32'(bad_addr), 32'd0);
        check("write_data", 32'(bad_data), 32'd0);
        check("misalign_exc", 32'(misalign_exc), 32'(mis));
        check("mem_word", mem[widx], v.exp_word);
        if (load_op || (!mis && !store_op)) begin
            check("wb_result", wb_result, v.exp_result);
            check("wb_dst", 32'(wb_dst), 32'(v.dst));
            check("wb_write_back", 32'(wb_write_back), 32'(v.wb));
        end else begin
            check("wb_write_back", 32'(wb_write_back), 32'd0);
        end

        // The following MEM_NONE must be accepted on the first idle edge.
        @(negedge clk);
        check("b2b_wb_result", wb_result, follow);
        check("b2b_wb_write_back", 32'(wb_write_back), 32'd0);
        check("exc_pulse_end", 32'(misalign_exc), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_daddr"}, daddr, 32'd0);
        check({tag, "_dread"}, 32'(dread), 32'd0);
        check({tag, "_dwrite"}, 32'(dwrite), 32'd0);
        check({tag, "_stall"}, 32'(mem_stall), 32'd0);
        check({tag, "_wb_dst"}, 32'(wb_dst), 32'd0);
        check({tag, "_wb_result"}, wb_result, 32'd0);
        check({tag, "_wb_we"}, 32'(wb_write_back), 32'd0);
        check({tag, "_exc"}, 32'(misalign_exc), 32'd0);
    endtask

    vec_t table_v [13];

    initial begin
        vec_t v;
        logic saw_write;

        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        table_v[0]  = '{MEM_NONE, 32'h12345678, 32'h0,        5'd5,  1'b1, 0, 32'h0,        32'h12345678, 32'h0};
        table_v[1]  = '{MEM_LB,   32'h103,      32'h0,        5'd7,  1'b1, 0, 32'h80FF1234, 32'hFFFFFF80, 32'h80FF1234};
        table_v[2]  = '{MEM_LBU,  32'h103,      32'h0,        5'd8,  1'b1, 0, 32'h80FF1234, 32'h00000080, 32'h80FF1234};
        table_v[3]  = '{MEM_SB,   32'h101,      32'hAB,       5'd9,  1'b1, 0, 32'h11223344, 32'h0,        32'h1122AB44};
        table_v[4]  = '{MEM_LW,   32'h202,      32'h0,        5'd10, 1'b1, 0, 32'h00000055, 32'h0,        32'h00000055};
        table_v[5]  = '{MEM_LH,   32'h2,        32'h0,        5'd11, 1'b1, 2, 32'h80011234, 32'hFFFF8001, 32'h80011234};
        table_v[6]  = '{MEM_LHU,  32'h2,        32'h0,        5'd12, 1'b0, 0, 32'h80011234, 32'h00008001, 32'h80011234};
        table_v[7]  = '{MEM_SH,   32'h106,      32'hCAFEBEEF, 5'd13, 1'b1, 1, 32'h11223344, 32'h0,        32'hBEEF3344};
        table_v[8]  = '{MEM_SW,   32'h10C,      32'hA5A55A5A, 5'd14, 1'b1, 0, 32'h0,        32'h0,        32'hA5A55A5A};
        table_v[9]  = '{MEM_LW,   32'h10C,      32'h0,        5'd15, 1'b1, 0, 32'h76543210, 32'h76543210, 32'h76543210};
        table_v[10] = '{MEM_SH,   32'h105,      32'h1234,     5'd16, 1'b0, 0, 32'h99999999, 32'h0,        32'h99999999};
        table_v[11] = '{MEM_LB,   32'h100,      32'h0,        5'd17, 1'b1, 0, 32'h0000007F, 32'h0000007F, 32'h0000007F};
        table_v[12] = '{MEM_SB,   32'h103,      32'h12,       5'd18, 1'b0, 2, 32'hFFFFFFFF, 32'h0,        32'h12FFFFFF};

        rst = 1'b1; dready = 1'b0;
        ex_result = '0; ex_store_data = '0; ex_dst = '0; ex_write_back = 1'b0; ex_mem_op = MEM_NONE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_op(table_v[i], i);

        for (int i = 0; i < 60; i++) begin
            v.op        = 4'($urandom_range(0, 8));
            v.addr      = 32'($urandom_range(0, 1023));
            v.sdata     = $urandom;
            v.dst       = 5'($urandom_range(0, 31));
            v.wb        = 1'($urandom_range(0, 1));
            v.delay     = $urandom_range(0, 2);
            v.init_word = $urandom;
            if (v.op == MEM_NONE) v.addr = $urandom;
            v.exp_result = (v.op == MEM_NONE) ? v.addr : ref_load(v.op, v.addr, v.init_word);
            v.exp_word   = ref_misaligned(v.op, v.addr) ? v.init_word
                                                        : ref_store(v.op, v.addr, v.init_word, v.sdata);
            run_op(v, 100 + i);
        end

        // SW stalled by DReady, reset lands during the third wait cycle.
        mem[8'hC0] = 32'h01020304;
        @(negedge clk);
        ex_mem_op = MEM_SW; ex_result = 32'h300; ex_store_data = 32'hDEADBEEF;
        ex_dst = 5'd3; ex_write_back = 1'b1; dready = 1'b0;
        @(posedge clk);
        #1;
        ex_mem_op = MEM_NONE; ex_write_back = 1'b0; ex_result = 32'd0; ex_dst = 5'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("sw_hold_dwrite", 32'(dwrite), 32'd1);
            check("sw_hold_data", bus_data, 32'hDEADBEEF);
            check("sw_hold_daddr", daddr, 32'h000000C0);
        end
        $display("op=%0d addr=%h reset during write wait", MEM_SW, 32'h300);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("sw_reset");
        check("sw_reset_mem", mem[8'hC0], 32'h01020304);
        rst = 1'b0;

        // SH abandoned in RMW_READ by reset: no write may follow.
        mem[8'h42] = 32'h55667788;
        @(negedge clk);
        ex_mem_op = MEM_SH; ex_result = 32'h108; ex_store_data = 32'h1234;
        ex_dst = 5'd4; ex_write_back = 1'b0; dready = 1'b0;
        @(posedge clk);
        #1;
        ex_mem_op = MEM_NONE; ex_result = 32'd0;
        @(negedge clk);
        check("rmw_read_dread", 32'(dread), 32'd1);
        check("rmw_read_daddr", daddr, 32'h00000042);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dready = 1'b1;
        saw_write = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (dwrite || mem_stall) saw_write = 1'b1;
        end
        dready = 1'b0;
        $display("op=%0d addr=%h reset during rmw read", MEM_SH, 32'h108);
        check("rmw_reset_no_write", 32'(saw_write), 32'd0);
        check("rmw_reset_mem", mem[8'h42], 32'h55667788);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and register write-back in the MIPS CPU. Takes the ALU result and store data from execute, performs word, halfword and byte loads/stores on the data bus (DAddr/Data/DRead/DWrite), and registers the write-back triple consumed by the register file. Sub-word stores use read-modify-write because the bus has no byte enables. While an access is in flight, the stage stalls upstream.

## Interface
Parameters: none; encodings come from the shared package.

- Clk  in  1  clock
- Reset  in  1  reset Reset, synchronous, active-high; clock Clk
- ex_result  in  32  ALU result; effective byte address for memory ops
- ex_store_data  in  32  rt value for stores
- ex_dst  in  5  destination register
- ex_write_back  in  1  execute requests a register write
- ex_mem_op  in  4  MEM_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW
- DReady  in  1  bus completes the current DRead/DWrite this cycle
- DAddr  out  32  word address {2'b0, addr[31:2]}; 0 when idle
- Data  inout  32  driven only while DWrite=1, else high-Z
- DRead, DWrite  out  1  bus strobes; never both high
- mem_stall  out  1  stage busy; upstream must hold
- wb_dst  out  5  registered destination
- wb_result  out  32  registered write-back value
- wb_write_back  out  1  registered write enable
- misalign_exc  out  1  one-cycle pulse on a misaligned access

## Operation
- **Capture.** Inputs are sampled at a posedge only when mem_stall=0. Address, store data, op and dst are latched.
- **MEM_NONE.** The same edge loads wb_result=ex_result, wb_dst, and wb_write_back=ex_write_back.
- **Misalignment.** LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0:
  - no bus cycle is issued;
  - misalign_exc=1 for one cycle;
  - wb_write_back=0.
- **FSM states:** IDLE, READ, WRITE, RMW_READ, RMW_WRITE.
  - From IDLE on capture: load → READ, SW → WRITE, SB/SH → RMW_READ.
  - READ: DRead=1. On DReady the aligned value goes to wb_result, wb_write_back takes the latched write_back, and the FSM → IDLE.
  - WRITE: DWrite=1 with Data=store word. On DReady → IDLE.
  - RMW_READ: DRead=1. On DReady the read word is merged with the store lane(s) into a register, then → RMW_WRITE.
  - RMW_WRITE: DWrite=1 with the merged word. On DReady → IDLE.
  - Without DReady, every state holds and all bus outputs stay stable.
- **Lanes (little-endian).**
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword: addr[1]=1 selects [31:16], otherwise [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - SB/SH replace only the addressed lane(s).
- mem_stall = (state ≠ IDLE). It is registered-derived, with no combinational path from DReady or the ex_* inputs.
- wb_write_back=0 on every edge that does not complete a load or capture a MEM_NONE op. Stores never write back.

## Timing
- **Reset values:** state IDLE; DAddr=0; DRead=0; DWrite=0; Data high-Z; mem_stall=0; wb_dst=0; wb_result=0; wb_write_back=0; misalign_exc=0.
- **MEM_NONE:** 1-cycle latency, no stall.
- **Loads and SW with DReady tied high:** 1 bus cycle, mem_stall high for 1 cycle, result at the edge ending the READ cycle.
- **SB/SH with DReady tied high:** 2 bus cycles, mem_stall high for 2 cycles.
- **Bus strobes:** high for the full state duration; DAddr is valid whenever either strobe is high.
- **Reset mid-operation:** the op is abandoned at that edge and strobes drop. If the reset lands in RMW_READ, no write is ever issued.
- **Back-to-back ops:** a new op is accepted in the first cycle after returning to IDLE.

## Structure
- **Shared package (mips_pkg):**
  - mem_op encoding (4-bit constants);
  - mem_state enumeration;
  - the width constant 32.
- **Sub-module mem_lane_align** (combinational):
  - inputs op, addr[1:0], bus word, store data;
  - outputs the extended load value and the merged store word.
- The FSM, capture registers, tri-state driver and WB registers live in mem_stage.

## Test plan
- MEM_NONE with ex_result=0x12345678, dst=5, write_back=1 → next edge wb_result=0x12345678, wb_dst=5, wb_write_back=1, mem_stall never high.
- LB at addr 0x103, memory word 0x80FF1234, DReady=1 → DAddr=0x40, DRead for one cycle, wb_result=0xFFFFFF80; LBU at the same address → 0x00000080.
- SB addr 0x101, store data 0xAB, old word 0x11223344 → RMW_READ then RMW_WRITE, Data=0x1122AB44, mem_stall high for 2 cycles.
- LW addr 0x202 → misalign_exc pulse, DRead/DWrite stay 0, wb_write_back=0.
- SW with DReady low for 3 cycles, Reset during the third → DWrite held stable, then drops at the reset edge, and all outputs take their reset values.
- LH addr 0x2 with word 0x8001xxxx, DReady delayed 2 cycles → mem_stall high for 3 cycles, wb_result=0xFFFF8001.
